wb_uart_tx: RTL and testbench

//  Wishbone classic slave UART transmitter on the cpu_wb data bus, alongside mem.
//  CPU writes bytes into a TX FIFO; a frame FSM serialises them 8N1 on tx_o.

---
 rtl/wb_uart_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_tx.sv
// Wishbone classic slave 8N1 UART transmitter with a TX FIFO and a programmable baud divisor.
// Define UART_TX_IRQ_EN to add the irq_o port and a writable CTRL[0] interrupt enable.
module wb_uart_tx #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic        tx_o
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic           r_ack;
  logic [31:0]    r_dat;
  logic           r_tx;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [15:0]    r_div;
  logic           r_ovf;
  state_t         r_state;
  logic [15:0]    r_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [15:0]    r_div_lat;

  logic           w_req;
  logic           w_wr;
  logic           w_rd;
  logic           w_push_req;
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic           w_busy;
  logic           w_stat_rd;
  logic [7:0]     w_count8;
  logic [7:0]     w_fifo_dout;
  logic [31:0]    w_rdata;
  logic           w_bit_end;
  logic           w_tx_nxt;
  state_t         w_state_nxt;
  logic           w_unused;

  assign w_unused = ^{adr_i[29:2], dat_i[31:16], sel_i[3:2]};

  // Bus decode: a request is only seen while ack_o is low, forcing a low cycle between acks.
  assign w_req      = cyc_i & stb_i & ~r_ack;
  assign w_wr       = w_req & we_i;
  assign w_rd       = w_req & ~we_i;
  assign w_push_req = w_wr & (adr_i[1:0] == 2'd0) & sel_i[0];
  assign w_stat_rd  = w_rd & (adr_i[1:0] == 2'd1);

  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = w_push_req & ~w_full;
  assign w_busy      = (r_state != S_IDLE);
  assign w_count8    = 8'(r_count);
  assign w_fifo_dout = r_mem[r_rd_ptr];

`ifdef UART_TX_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && adr_i[1:0] == 2'd3 && sel_i[0]) begin
        r_irq_en <= dat_i[0];
      end
      r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
    end
  end

  assign irq_o = r_irq;
`endif

  always_comb begin
    w_rdata = '0;
    case (adr_i[1:0])
      2'd1:    w_rdata = {16'h0, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
      2'd2:    w_rdata = {16'h0, r_div};
`ifdef UART_TX_IRQ_EN
      2'd3:    w_rdata = {31'h0, r_irq_en};
`endif
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_div <= DEFAULT_DIV;
      r_ovf <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : '0;
      if (w_wr && adr_i[1:0] == 2'd2) begin
        if (sel_i[0]) r_div[7:0]  <= dat_i[7:0];
        if (sel_i[1]) r_div[15:8] <= dat_i[15:8];
      end
      // A dropped push wins over a simultaneous STAT read so the overflow is never lost.
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= dat_i[7:0];
  end

  assign w_bit_end = (r_cnt == r_div_lat);

  // Frame sequencing: tx_o is registered from the current state, so it lags the state by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx_nxt = 1'b0;
        if (w_bit_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_bit_end && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      if (w_pop || r_state == S_IDLE || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_pop) begin
        r_bit_idx <= '0;
      end else if (r_state == S_DATA && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // The divisor is latched at pop so DIV writes only affect the following frame.
  always_ff @(posedge clk_i) begin
    if (w_pop) begin
      r_shift   <= w_fifo_dout;
      r_div_lat <= r_div;
    end else if (r_state == S_DATA && w_bit_end) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  assign ack_o = r_ack;
  assign dat_o = r_dat;
  assign tx_o  = r_tx;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboard bench for wb_uart_tx: bus reads and serial frames are checked by independent monitors.
module tb_wb_uart_tx;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [29:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        tx_o;
`ifdef UART_TX_IRQ_EN
  logic        irq_o;
`endif

  wb_uart_tx #(
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .adr_i(adr_i),
    .dat_i(dat_i),
    .sel_i(sel_i),
    .cyc_i(cyc_i),
    .stb_i(stb_i),
    .we_i (we_i),
    .ack_o(ack_o),
    .dat_o(dat_o),
    .tx_o (tx_o)
`ifdef UART_TX_IRQ_EN
    ,
    .irq_o(irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] b;
    int         d;
  } frame_t;

  frame_t      exp_tx[$];
  logic [31:0] exp_rd[$];
  int          starts[$];
  int          frames_done = 0;

  // Bus read monitor
  logic        prev_ack = 1'b0;
  logic [31:0] rd_e;
  always @(negedge clk_i) begin
    if (ack_o === 1'b1) begin
      checks++;
      if (prev_ack) begin
        failures++;
        $display("FAIL ack_width got=2+ cycles required=1 at cycle %0d", cyc_cnt);
      end
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack got=ack required=no ack at cycle %0d", cyc_cnt);
      end else begin
        rd_e = exp_rd.pop_front();
        if (dat_o !== rd_e) begin
          failures++;
          $display("FAIL bus_rdata got=%08h required=%08h at cycle %0d", dat_o, rd_e, cyc_cnt);
        end
      end
    end
    prev_ack = ack_o;
  end

  // Serial monitor: compares every sample of a frame against the ideal waveform
  bit     rx_active = 0;
  bit     rx_skip = 0;
  int     rx_k;
  int     rx_bit;
  frame_t rx_f;
  bit     rx_bad;
  int     rx_bad_k;
  logic   rx_bad_v;
  logic   rx_lvl;
  always @(negedge clk_i) begin
    if (rst_i) begin
      rx_active = 0;
      rx_skip   = 0;
    end else if (rx_skip) begin
      if (tx_o === 1'b1) rx_skip = 0;
    end else if (!rx_active) begin
      if (tx_o === 1'b0) begin
        if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected_frame got=start bit at cycle %0d required=idle", cyc_cnt);
          rx_skip = 1;
        end else begin
          rx_f      = exp_tx.pop_front();
          rx_active = 1;
          rx_k      = 0;
          rx_bad    = 0;
          starts.push_back(cyc_cnt);
        end
      end
    end else begin
      rx_k++;
      rx_bit = rx_k / (rx_f.d + 1);
      if (rx_bit == 0) rx_lvl = 1'b0;
      else if (rx_bit <= 8) rx_lvl = rx_f.b[rx_bit-1];
      else rx_lvl = 1'b1;
      if (tx_o !== rx_lvl && !rx_bad) begin
        rx_bad   = 1;
        rx_bad_k = rx_k;
        rx_bad_v = tx_o;
      end
      if (rx_k == 10 * (rx_f.d + 1) - 1) begin
        checks++;
        if (rx_bad) begin
          failures++;
          $display("FAIL tx_frame byte=%02h div=%0d sample %0d got=%b required=%b",
                   rx_f.b, rx_f.d, rx_bad_k, rx_bad_v, ~rx_bad_v);
        end
        rx_active = 0;
        frames_done++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h at cycle %0d", name, got, req, cyc_cnt);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wb(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, input logic [31:0] exp);
    exp_rd.push_back(we ? 32'h0 : exp);
    @(posedge clk_i);
    #1;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    we_i  = we;
    adr_i = {28'h0, adr};
    dat_i = dat;
    sel_i = sel;
    @(posedge clk_i);
    #1;
    chk("ack_latency", 32'(ack_o), 32'd1);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i;
    i = 0;
    while (frames_done < n && i < budget) begin
      @(posedge clk_i);
      i++;
    end
    #1;
    chk("wait_frames", 32'(frames_done >= n), 32'd1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    int i;
    i = 0;
    while (starts.size() < n && i < budget) begin
      @(posedge clk_i);
      i++;
    end
    #1;
    chk("wait_starts", 32'(starts.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    tick(1);
    chk("rst_tx_next_edge", 32'(tx_o), 32'd1);
    rst_i = 1'b0;
    exp_tx.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fd;
    bit  hold_ok;
    rst_i = 1'b1;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    tick(3);
    rst_i = 1'b0;

    // Reset state
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0002);
    wb(1'b0, 2'd2, 32'h0, 4'hF, 32'd433);
    wb(1'b0, 2'd0, 32'h0, 4'hF, 32'h0);
    wb(1'b0, 2'd3, 32'h0, 4'hF, 32'h0);

    // Single frame 0x55, DIV=3
    wb(1'b1, 2'd2, 32'h0000_0003, 4'h3, 32'h0);
    exp_tx.push_back('{8'h55, 3});
    wb(1'b1, 2'd0, 32'h0000_0055, 4'h1, 32'h0);
    chk("t2_tx_hold", 32'(tx_o), 32'd1);
    tick(1);
    chk("t2_tx_pre", 32'(tx_o), 32'd1);
    tick(1);
    chk("t2_tx_fall", 32'(tx_o), 32'd0);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0006);
    wait_frames(1, 100);
    tick(2);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0002);

    // Back-to-back frames
    starts.delete();
    exp_tx.push_back('{8'h01, 3});
    exp_tx.push_back('{8'h02, 3});
    exp_tx.push_back('{8'h03, 3});
    wb(1'b1, 2'd0, 32'h01, 4'h1, 32'h0);
    wb(1'b1, 2'd0, 32'h02, 4'h1, 32'h0);
    wb(1'b1, 2'd0, 32'h03, 4'h1, 32'h0);
    wait_starts(1, 20);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0204);
    wait_starts(2, 100);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0104);
    wait_starts(3, 100);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0006);
    wait_frames(4, 200);
    chk("t3_gap1", 32'(starts[1] - starts[0]), 32'd40);
    chk("t3_gap2", 32'(starts[2] - starts[1]), 32'd40);

    // FIFO overflow with a very slow divisor, then reset mid-frame
    wb(1'b1, 2'd2, 32'h0000_FFFF, 4'h3, 32'h0);
    exp_tx.push_back('{8'h00, 65535});
    for (int i = 0; i < 18; i++) wb(1'b1, 2'd0, 32'(i), 4'h1, 32'h0);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_100D);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_1005);
    do_reset();
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0002);
    wb(1'b0, 2'd2, 32'h0, 4'hF, 32'd433);

    // DATA write without sel_i[0] is ignored
    wb(1'b1, 2'd0, 32'h0000_00AB, 4'b1110, 32'h0);
    hold_ok = 1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (tx_o !== 1'b1) hold_ok = 0;
    end
    chk("t5_tx_idle", 32'(hold_ok), 32'd1);
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0002);

    // DIV change mid-frame applies to the next frame only
    fd = frames_done;
    wb(1'b1, 2'd2, 32'h0000_0003, 4'h3, 32'h0);
    starts.delete();
    exp_tx.push_back('{8'h3C, 3});
    exp_tx.push_back('{8'hC3, 1});
    wb(1'b1, 2'd0, 32'h3C, 4'h1, 32'h0);
    wait_starts(1, 20);
    wb(1'b1, 2'd2, 32'h0000_0001, 4'h3, 32'h0);
    wb(1'b1, 2'd0, 32'hC3, 4'h1, 32'h0);
    wb(1'b0, 2'd2, 32'h0, 4'hF, 32'h0000_0001);
    wait_frames(fd + 2, 200);
    chk("t5_gap", 32'(starts[1] - starts[0]), 32'd40);

    // Reset during data bits flushes the FIFO
    wb(1'b1, 2'd2, 32'h0000_0003, 4'h3, 32'h0);
    exp_tx.push_back('{8'h00, 3});
    exp_tx.push_back('{8'h00, 3});
    wb(1'b1, 2'd0, 32'h00, 4'h1, 32'h0);
    wb(1'b1, 2'd0, 32'h00, 4'h1, 32'h0);
    tick(4);
    chk("t6_pre_reset_tx", 32'(tx_o), 32'd0);
    do_reset();
    wb(1'b0, 2'd1, 32'h0, 4'hF, 32'h0000_0002);
    wb(1'b0, 2'd2, 32'h0, 4'hF, 32'd433);

    // CTRL / interrupt
    wb(1'b1, 2'd3, 32'h0000_0001, 4'h1, 32'h0);
`ifdef UART_TX_IRQ_EN
    wb(1'b0, 2'd3, 32'h0, 4'hF, 32'h0000_0001);
    tick(2);
    chk("irq_idle", 32'(irq_o), 32'd1);
    wb(1'b1, 2'd2, 32'h0000_0003, 4'h3, 32'h0);
    fd = frames_done;
    exp_tx.push_back('{8'h81, 3});
    wb(1'b1, 2'd0, 32'h81, 4'h1, 32'h0);
    chk("irq_push_edge", 32'(irq_o), 32'd1);
    tick(1);
    chk("irq_drop", 32'(irq_o), 32'd0);
    wait_frames(fd + 1, 100);
    tick(3);
    chk("irq_after_stop", 32'(irq_o), 32'd1);
`else
    wb(1'b0, 2'd3, 32'h0, 4'hF, 32'h0);
`endif

    tick(5);
    chk("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    chk("exp_tx_drained", 32'(exp_tx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
